// File: rtl/sdram_write_fifo_pkg.sv
// Shared entry layout for the SDRAM write-data buffer.
// An entry is {byte_mask[3:0], data[31:0]}, and the mask bits are the MSBs.
package sdram_write_fifo_pkg;
    localparam int WFIFO_W        = 36;
    localparam int WFIFO_MASK_MSB = 35;
    localparam int WFIFO_MASK_LSB = 32;

    typedef logic [WFIFO_W-1:0] wfifo_entry_t;

    function automatic wfifo_entry_t pack_entry(input logic [3:0] mask, input logic [31:0] data);
        return {mask, data};
    endfunction
endpackage

// File: rtl/sdram_write_fifo_ram.sv
// Storage array for the write buffer: a synchronous write port and an asynchronous read port.
// Latency: a write lands at the clock edge. A read is combinational. There is no backpressure.
// The array is deliberately not reset.
module sdram_fifo_ram
    import sdram_write_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  wfifo_entry_t         wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output wfifo_entry_t         rdata_o
);
    wfifo_entry_t mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sdram_write_fifo.sv
// This is the first-word-fall-through write-data buffer that feeds the SDRAM write engine.
// Latency: a word pushed into an empty FIFO is visible on fifo_data after one edge. A full FIFO drops in_stb (overflow is sticky).
module sdram_write_fifo
    import sdram_write_fifo_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_stb,
    input  logic [31:0]         in_data,
    input  logic [3:0]          in_mask,
    output logic                in_ready,
    output logic                almost_full,
    output logic [WFIFO_W-1:0]  fifo_data,
    output logic                fifo_empty,
    input  logic                fifo_rd,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic                underflow
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    wfifo_entry_t      head_q, head_d, ram_rdata;
    logic              in_ready_q, almost_full_q, empty_q, ovf_q, unf_q;
    logic              push, pop;

    assign push = in_stb & in_ready_q;
    assign pop  = fifo_rd & ~empty_q;

    sdram_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (push & ~flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (pack_entry(in_mask, in_data)),
        .raddr_i (rd_ptr_q + PTR_ONE),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
            // The head comes from the array unless the incoming word becomes the only entry.
            if (pop && count_q > CNT_ONE)
                head_d = ram_rdata;
            else if (push && (count_q == CNT_ZERO || (pop && count_q == CNT_ONE)))
                head_d = pack_entry(in_mask, in_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            head_q        <= '0;
            in_ready_q    <= 1'b1;
            almost_full_q <= 1'b0;
            empty_q       <= 1'b1;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            head_q        <= head_d;
            in_ready_q    <= (count_d < CNT_DEPTH);
            almost_full_q <= (count_d >= CNT_AFULL);
            empty_q       <= (count_d == CNT_ZERO);
            ovf_q         <= ovf_q | (in_stb & ~in_ready_q);
            unf_q         <= unf_q | (fifo_rd & empty_q);
        end
    end

    assign in_ready    = in_ready_q;
    assign almost_full = almost_full_q;
    assign fifo_data   = head_q;
    assign fifo_empty  = empty_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
endmodule

// File: tb/tb_sdram_write_fifo.sv
// Testbench for sdram_write_fifo. It applies a table of reset-relative vectors, then hand-written corner sequences, then a random stream.
// The random stream is checked against a queue-based reference model.
module tb_sdram_write_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, in_stb = 1'b0, fifo_rd = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_mask = '0;
    logic        in_ready, almost_full, fifo_empty, overflow, underflow;
    logic [35:0] fifo_data;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;

    sdram_write_fifo #(.ADDR_W(4), .AFULL_LVL(12)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_stb(in_stb), .in_data(in_data),
        .in_mask(in_mask), .in_ready(in_ready), .almost_full(almost_full),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush, stb;
        logic [31:0] d;
        logic [3:0]  m;
        logic        rd;
        logic [4:0]  cnt;
        logic        empty, ready;
        logic [35:0] data;
        logic        ovf, unf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic f, input logic s, input logic [31:0] d,
                         input logic [3:0] m, input logic r);
        flush = f; in_stb = s; in_data = d; in_mask = m; fifo_rd = r;
        @(posedge clk);
        #1;
        flush = 1'b0; in_stb = 1'b0; fifo_rd = 1'b0;
    endtask

    task automatic do_reset();
        flush = 1'b0; in_stb = 1'b0; fifo_rd = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_data", 64'(fifo_data), 64'd0);
        chk("rst_flags", 64'({almost_full, overflow, underflow}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic f, input logic s, input logic [31:0] d, input logic [3:0] m,
                                input logic r, input logic [4:0] c, input logic e, input logic rdy,
                                input logic [35:0] dat, input logic o, input logic u);
        vec_t v;
        v.flush = f; v.stb = s; v.d = d; v.m = m; v.rd = r;
        v.cnt = c; v.empty = e; v.ready = rdy; v.data = dat; v.ovf = o; v.unf = u;
        return v;
    endfunction

    logic [35:0] q[$];
    logic [35:0] mhead;
    logic [35:0] w;
    int popped;

    initial begin
        vecs[0]  = mk(0,1,32'hDEADBEEF,4'h0,0, 5'd1,0,1,36'h0DEADBEEF,0,0);
        vecs[1]  = mk(0,0,32'h0,4'h0,1,        5'd0,1,1,36'h0DEADBEEF,0,0);
        vecs[2]  = mk(0,0,32'h0,4'h0,1,        5'd0,1,1,36'h0DEADBEEF,0,1);
        vecs[3]  = mk(0,1,32'hA0,4'h1,0,       5'd1,0,1,36'h1000000A0,0,1);
        vecs[4]  = mk(0,1,32'hA1,4'h2,0,       5'd2,0,1,36'h1000000A0,0,1);
        vecs[5]  = mk(0,1,32'hA2,4'h3,0,       5'd3,0,1,36'h1000000A0,0,1);
        vecs[6]  = mk(0,0,32'h0,4'h0,1,        5'd2,0,1,36'h2000000A1,0,1);
        vecs[7]  = mk(0,0,32'h0,4'h0,1,        5'd1,0,1,36'h3000000A2,0,1);
        vecs[8]  = mk(0,1,32'hA3,4'h4,1,       5'd1,0,1,36'h4000000A3,0,1);
        vecs[9]  = mk(0,1,32'hA4,4'h5,1,       5'd1,0,1,36'h5000000A4,0,1);
        vecs[10] = mk(0,0,32'h0,4'h0,1,        5'd0,1,1,36'h5000000A4,0,1);
        vecs[11] = mk(0,1,32'hA5,4'h6,1,       5'd1,0,1,36'h6000000A5,0,1);
        vecs[12] = mk(0,0,32'h0,4'h0,1,        5'd0,1,1,36'h6000000A5,0,1);

        #3;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].flush, vecs[i].stb, vecs[i].d, vecs[i].m, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d_empty_ready", i), 64'({fifo_empty, in_ready}), 64'({vecs[i].empty, vecs[i].ready}));
            chk($sformatf("vec%0d_data", i), 64'(fifo_data), 64'(vecs[i].data));
            chk($sformatf("vec%0d_flags", i), 64'({overflow, underflow}), 64'({vecs[i].ovf, vecs[i].unf}));
        end

        // Fill to full, then overflow, then full+pop+push drops the push.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 32'(i), 4'(i), 0);
            chk("fill_count", 64'(count), 64'(i + 1));
            chk("fill_afull", 64'(almost_full), 64'((i + 1) >= 12));
            chk("fill_ready", 64'(in_ready), 64'((i + 1) < 16));
        end
        cycle(0, 1, 32'h99, 4'h0, 0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        cycle(0, 1, 32'h77, 4'h0, 1);
        chk("fullpop_count", 64'(count), 64'd15);
        chk("fullpop_ready", 64'(in_ready), 64'd1);
        for (int j = 1; j < 16; j++) begin
            w = {4'(j), 32'(j)};
            chk("drain_data", 64'(fifo_data), 64'(w));
            cycle(0, 0, 32'h0, 4'h0, 1);
        end
        chk("drain_empty", 64'({fifo_empty, count}), 64'({1'b1, 5'd0}));
        chk("drain_flags", 64'({overflow, underflow}), 64'({1'b1, 1'b0}));

        // Asynchronous reset with 7 entries held.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(0, 1, 32'h100 + 32'(i), 4'hF, 0);
        chk("pre_rst_count", 64'(count), 64'd7);
        rst = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_state", 64'({fifo_empty, in_ready, fifo_data}), 64'({1'b1, 1'b1, 36'h0}));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Flush with 5 entries held: sticky underflow and the stale head survive.
        cycle(0, 0, 32'h0, 4'h0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h50 + 32'(i), 4'(i), 0);
        chk("pre_flush_count", 64'(count), 64'd5);
        cycle(1, 1, 32'hEE, 4'h0, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_state", 64'({fifo_empty, in_ready, almost_full}), 64'({1'b1, 1'b1, 1'b0}));
        chk("flush_flags", 64'({overflow, underflow}), 64'({1'b0, 1'b1}));
        chk("flush_data", 64'(fifo_data), 64'(36'h000000050));
        cycle(0, 1, 32'h1234, 4'h9, 0);
        chk("post_flush_push", 64'({count, fifo_data}), 64'({5'd1, 36'h900001234}));

        // Random legal traffic against a queue model.
        do_reset();
        q.delete();
        mhead = '0;
        popped = 0;
        for (int c = 0; c < 600; c++) begin
            logic s, r, f;
            logic [31:0] d;
            logic [3:0] m;
            f = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 2) != 0) && (q.size() < 16);
            r = ($urandom_range(0, 1) == 1) && (q.size() > 0);
            d = $urandom;
            m = 4'($urandom);
            cycle(f, s, d, m, r);
            if (f) q.delete();
            else begin
                if (r) begin void'(q.pop_front()); popped++; end
                if (s) q.push_back({m, d});
            end
            if (q.size() > 0) mhead = q[0];
            chk("rnd_count", 64'(count), 64'(q.size()));
            chk("rnd_status", 64'({fifo_empty, in_ready, almost_full}),
                64'({q.size() == 0, q.size() < 16, q.size() >= 12}));
            chk("rnd_data", 64'(fifo_data), 64'(mhead));
            chk("rnd_flags", 64'({overflow, underflow}), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
